// File: rtl/bus_copy_dma.sv
// bus_copy_dma: second bus master that copies len 32-bit words from src to dst.
// Define BUS_COPY_DMA_TIMEOUT_EN to abort a copy whose response stalls for TIMEOUT cycles.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module bus_copy_dma #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [ADDR_WIDTH-1:0]     src_i,
  input  logic [ADDR_WIDTH-1:0]     dst_i,
  input  logic [LEN_WIDTH-1:0]      len_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [ADDR_WIDTH-1:0]     err_addr_o,
  output logic [LEN_WIDTH-1:0]      remaining_o,
  output logic [ADDR_WIDTH-1:0]     addr_o,
  output logic                      w_rb_o,
  output logic [`BUS_ACC_WIDTH-1:0] acc_o,
  input  logic [`BUS_WIDTH-1:0]     rdata_i,
  output logic [`BUS_WIDTH-1:0]     wdata_o,
  output logic                      req_o,
  input  logic                      resp_i,
  input  logic                      fault_i
);

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT} state_t;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  src_q, dst_q, err_addr_q, addr_q;
  logic [LEN_WIDTH-1:0]   rem_q;
  logic [`BUS_WIDTH-1:0]  wdata_q;
  logic                   busy_q, done_q, err_q, w_rb_q, req_q, abort_q;

  logic [ADDR_WIDTH-1:0]  src_d, dst_d;
  logic [LEN_WIDTH-1:0]   rem_d;
  logic                   abort_d, last_d;

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("bus_copy_dma: TIMEOUT must be at least 1");
  end

  assign src_d   = src_q + ADDR_WIDTH'(4);
  assign dst_d   = dst_q + ADDR_WIDTH'(4);
  assign rem_d   = rem_q - LEN_WIDTH'(1);
  // abort arriving in the same cycle as resp still ends the copy at that resp
  assign abort_d = abort_q | abort_i;
  assign last_d  = (rem_q == LEN_WIDTH'(1)) | abort_d;

`ifdef BUS_COPY_DMA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q;
  logic             stall_d;
  assign stall_d = (cnt_q == CNT_LAST);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      err_addr_q <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      w_rb_q     <= 1'b0;
      req_q      <= 1'b0;
      abort_q    <= 1'b0;
`ifdef BUS_COPY_DMA_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      req_q  <= 1'b0;
      if (busy_q && abort_i) abort_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            src_q   <= src_i;
            dst_q   <= dst_i;
            rem_q   <= len_i;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            if (len_i == '0) begin
              done_q <= 1'b1;
            end else if (src_i[1:0] != 2'b00) begin
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_addr_q <= src_i;
            end else if (dst_i[1:0] != 2'b00) begin
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_addr_q <= dst_i;
            end else begin
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              w_rb_q  <= 1'b0;
              addr_q  <= src_i;
              state_q <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (fault_i) begin
            err_q      <= 1'b1;
            err_addr_q <= src_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            state_q <= S_RD_WAIT;
`ifdef BUS_COPY_DMA_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_RD_WAIT: begin
          if (resp_i) begin
            if (abort_d) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              wdata_q <= rdata_i;
              req_q   <= 1'b1;
              w_rb_q  <= 1'b1;
              addr_q  <= dst_q;
              state_q <= S_WR_REQ;
            end
          end
`ifdef BUS_COPY_DMA_TIMEOUT_EN
          else if (stall_d) begin
            err_q      <= 1'b1;
            err_addr_q <= src_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        S_WR_REQ: begin
          if (fault_i) begin
            err_q      <= 1'b1;
            err_addr_q <= dst_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            state_q <= S_WR_WAIT;
`ifdef BUS_COPY_DMA_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_WR_WAIT: begin
          if (resp_i) begin
            src_q <= src_d;
            dst_q <= dst_d;
            rem_q <= rem_d;
            if (last_d) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              req_q   <= 1'b1;
              w_rb_q  <= 1'b0;
              addr_q  <= src_d;
              state_q <= S_RD_REQ;
            end
          end
`ifdef BUS_COPY_DMA_TIMEOUT_EN
          else if (stall_d) begin
            err_q      <= 1'b1;
            err_addr_q <= dst_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
  assign remaining_o = rem_q;
  assign addr_o      = addr_q;
  assign w_rb_o      = w_rb_q;
  assign acc_o       = `BUS_ACC_4B;
  assign wdata_o     = wdata_q;
  assign req_o       = req_q;

endmodule

// File: tb/tb_bus_copy_dma.sv
// Self-checking bench for bus_copy_dma: memory responder with random latency plus directed copies.
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_bus_copy_dma;
`ifdef BUS_COPY_DMA_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic rst, start, abort, busy, done, err, w_rb, req, resp, fault;
  logic [31:0] src, dst, err_addr, addr, rdata, wdata;
  logic [15:0] len, remaining;
  logic [`BUS_ACC_WIDTH-1:0] acc;

  always #5 clk = ~clk;

  bus_copy_dma #(.ADDR_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .src_i(src), .dst_i(dst), .len_i(len),
    .abort_i(abort), .busy_o(busy), .done_o(done), .err_o(err), .err_addr_o(err_addr),
    .remaining_o(remaining), .addr_o(addr), .w_rb_o(w_rb), .acc_o(acc), .rdata_i(rdata),
    .wdata_o(wdata), .req_o(req), .resp_i(resp), .fault_i(fault)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat_max;
  bit fault_en, stall_en;
  logic [31:0] fault_addr, stall_addr, salt;

  int rcnt;
  bit outstanding, pend_rd;
  logic [31:0] pend_addr;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int req_cnt = 0;
  int viol_cnt = 0;
  int bd_viol = 0;
  int stall_cyc = 0;

  // Memory contents are a pure function of the address, so expected copies need no storage.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ salt;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) if (busy && done) bd_viol++;

  // Responder: fault is combinational in the req cycle; resp arrives 1+rand(0..lat_max) cycles later.
  always @(negedge clk) begin
    if (rst) begin
      resp = 1'b0; fault = 1'b0; rdata = '0; rcnt = 0; outstanding = 1'b0;
    end else begin
      fault = 1'b0;
      if (resp) begin resp = 1'b0; outstanding = 1'b0; end
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          resp = 1'b1;
          rdata = pend_rd ? word_at(pend_addr) : $urandom();
        end
      end
      if (req) begin
        req_cnt++;
        if (outstanding) viol_cnt++;
        if (fault_en && addr == fault_addr) fault = 1'b1;
        else begin
          outstanding = 1'b1;
          if (w_rb) begin wr_addr_q.push_back(addr); wr_data_q.push_back(wdata); end
          if (stall_en && addr == stall_addr) stall_cyc = cyc;
          else begin
            pend_addr = addr; pend_rd = !w_rb;
            rcnt = 1 + int'($urandom_range(lat_max, 0));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk); src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k, output bit busy_seen);
    k = -1; busy_seen = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      if (busy) busy_seen = 1'b1;
      if (done) begin k = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic check_writes(input string tag, input int base, input logic [31:0] s,
                              input logic [31:0] d, input int n);
    check({tag, " write count"}, 32'(wr_addr_q.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < wr_addr_q.size(); i++) begin
      check($sformatf("%s waddr%0d", tag, i), wr_addr_q[base+i], d + 32'(4 * i));
      check($sformatf("%s wdata%0d", tag, i), wr_data_q[base+i], word_at(s + 32'(4 * i)));
    end
  endtask

  initial begin
    int k, base, vbase, rbase;
    bit bs, found, dseen, bstay;
    logic [31:0] s, d;
    rst = 1'b1; start = 1'b0; abort = 1'b0; src = '0; dst = '0; len = '0;
    lat_max = 0; fault_en = 1'b0; stall_en = 1'b0; fault_addr = '0; stall_addr = '0;
    salt = $urandom();
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset err", 32'(err), 0);
    check("reset req", 32'(req), 0);
    check("reset w_rb", 32'(w_rb), 0);
    check("reset remaining", 32'(remaining), 0);
    check("reset err_addr", err_addr, 0);
    check("reset addr", addr, 0);
    check("reset wdata", wdata, 0);
    check("reset acc", 32'(acc), 32'(`BUS_ACC_4B));
    rst = 1'b0;

    // basic 3-word copy with a 1-cycle responder
    base = wr_addr_q.size(); vbase = viol_cnt;
    launch(32'h100, 32'h200, 16'd3);
    wait_done(60, k, bs);
    check("basic done cycle", 32'(k), 13);
    check("basic busy at done", 32'(busy), 0);
    check("basic err", 32'(err), 0);
    check("basic remaining", 32'(remaining), 0);
    @(negedge clk);
    check("basic done pulse width", 32'(done), 0);
    check_writes("basic", base, 32'h100, 32'h200, 3);
    check("basic overlap", 32'(viol_cnt - vbase), 0);

    // len = 0
    rbase = req_cnt;
    launch(32'h40, 32'h80, 16'd0);
    wait_done(10, k, bs);
    check("len0 done cycle", 32'(k), 1);
    check("len0 busy seen", 32'(bs), 0);
    check("len0 err", 32'(err), 0);
    check("len0 req count", 32'(req_cnt - rbase), 0);

    // misalignment, src checked before dst
    launch(32'h102, 32'h200, 16'd2);
    wait_done(10, k, bs);
    check("mis src done cycle", 32'(k), 1);
    check("mis src err", 32'(err), 1);
    check("mis src err_addr", err_addr, 32'h102);
    launch(32'h101, 32'h203, 16'd2);
    wait_done(10, k, bs);
    check("mis both err_addr", err_addr, 32'h101);
    launch(32'h100, 32'h202, 16'd2);
    wait_done(10, k, bs);
    check("mis dst err_addr", err_addr, 32'h202);
    check("mis busy seen", 32'(bs), 0);
    check("mis req count", 32'(req_cnt - rbase), 0);

    // write fault on second word
    fault_en = 1'b1; fault_addr = 32'h204;
    base = wr_addr_q.size();
    launch(32'h100, 32'h200, 16'd4);
    wait_done(80, k, bs);
    check("fault done seen", 32'(k > 0), 1);
    check("fault err", 32'(err), 1);
    check("fault err_addr", err_addr, 32'h204);
    check("fault remaining", 32'(remaining), 3);
    check_writes("fault", base, 32'h100, 32'h200, 1);
    rbase = req_cnt;
    repeat (20) @(negedge clk);
    check("fault no further req", 32'(req_cnt - rbase), 0);
    check("fault err sticky", 32'(err), 1);
    fault_en = 1'b0;

    // next accepted start clears err
    salt = $urandom();
    base = wr_addr_q.size();
    launch(32'h600, 32'h700, 16'd2);
    wait_done(40, k, bs);
    check("clear err", 32'(err), 0);
    check_writes("clear", base, 32'h600, 32'h700, 2);

    // abort during RD_WAIT of word 2
    lat_max = 2;
    base = wr_addr_q.size();
    launch(32'h400, 32'h800, 16'd5);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req && !w_rb && addr == 32'h404) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("abort word2 read seen", 32'(found), 1);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_done(40, k, bs);
    check("abort done seen", 32'(k > 0), 1);
    check("abort err", 32'(err), 0);
    check("abort remaining", 32'(remaining), 4);
    check_writes("abort", base, 32'h400, 32'h800, 1);

    // start while busy is ignored
    lat_max = 0;
    base = wr_addr_q.size();
    launch(32'h1000, 32'h2000, 16'd3);
    repeat (4) @(negedge clk);
    src = 32'h3000; dst = 32'h4000; len = 16'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(60, k, bs);
    check("busy start done cycle", 32'(k), 8);
    check("busy start remaining", 32'(remaining), 0);
    check_writes("busy start", base, 32'h1000, 32'h2000, 3);

    // source address wrap
    base = wr_addr_q.size();
    launch(32'hFFFF_FFFC, 32'h500, 16'd2);
    wait_done(40, k, bs);
    check("wrap done cycle", 32'(k), 9);
    check("wrap err", 32'(err), 0);
    check_writes("wrap", base, 32'hFFFF_FFFC, 32'h500, 2);

    // random addresses with variable responder latency
    for (int t = 0; t < 3; t++) begin
      salt = $urandom(); lat_max = 7;
      s = $urandom() & 32'hFFFF_FFFC;
      d = $urandom() & 32'hFFFF_FFFC;
      base = wr_addr_q.size(); vbase = viol_cnt;
      launch(s, d, 16'd16);
      wait_done(16 * 20 + 20, k, bs);
      check($sformatf("rand%0d done seen", t), 32'(k > 0), 1);
      check($sformatf("rand%0d err", t), 32'(err), 0);
      check($sformatf("rand%0d remaining", t), 32'(remaining), 0);
      check($sformatf("rand%0d overlap", t), 32'(viol_cnt - vbase), 0);
      check_writes($sformatf("rand%0d", t), base, s, d, 16);
    end

    // responder withholds the read of 0x108
    lat_max = 0; stall_en = 1'b1; stall_addr = 32'h108; stall_cyc = -1;
    base = wr_addr_q.size();
    launch(32'h100, 32'h300, 16'd4);
`ifdef BUS_COPY_DMA_TIMEOUT_EN
    wait_done(100, k, bs);
    check("timeout done seen", 32'(k > 0), 1);
    check("timeout err", 32'(err), 1);
    check("timeout err_addr", err_addr, 32'h108);
    check("timeout latency", 32'(cyc - stall_cyc), 11);
`else
    dseen = 1'b0; bstay = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
      if (!busy) bstay = 1'b0;
    end
    check("stall no done", 32'(dseen), 0);
    check("stall stays busy", 32'(bstay), 1);
`endif
    check_writes("stall", base, 32'h100, 32'h300, 2);
    stall_en = 1'b0;

    // reset mid-copy abandons without a done pulse
    launch(32'h100, 32'h200, 16'd8);
    repeat (3) @(negedge clk);
    rst = 1'b1; dseen = 1'b0;
    repeat (3) begin @(negedge clk); if (done) dseen = 1'b1; end
    rst = 1'b0;
    @(negedge clk);
    if (done) dseen = 1'b1;
    check("midreset no done", 32'(dseen), 0);
    check("midreset busy", 32'(busy), 0);
    check("midreset req", 32'(req), 0);
    check("busy and done overlap", 32'(bd_viol), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
